// File: rtl/jtag_sel_dr_bank_pkg.sv
// Shared types and helpers for the selectable JTAG data-register bank.
package jtag_sel_dr_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        SHIFT = 2'd2
    } dr_state_e;

    // Shift counter must hold 0..W+1 so that an over-shift stays distinguishable from W.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

    // Bit offset of register k inside a flattened NUM_REGS*W bus.
    function automatic int slice_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/jtag_sel_dr_bank_if.sv
// TAP-side strobes and chip-side data of the DR bank, bundled as one port.
interface jtag_sel_dr_bank_if #(
    parameter int JTAG_REG_WIDTH = 16,
    parameter int NUM_REGS       = 4,
    parameter int SEL_W          = 2
);
    logic                               sel;
    logic [SEL_W-1:0]                   reg_sel;
    logic                               captureDR;
    logic                               shiftDR;
    logic                               updateDR;
    logic                               scanin;
    logic [NUM_REGS*JTAG_REG_WIDTH-1:0] D;
    logic                               scanout;
    logic [NUM_REGS*JTAG_REG_WIDTH-1:0] Q;
    logic [NUM_REGS-1:0]                update_pulse;
    logic                               len_err;

    modport master (
        output sel, reg_sel, captureDR, shiftDR, updateDR, scanin, D,
        input  scanout, Q, update_pulse, len_err
    );

    modport slave (
        input  sel, reg_sel, captureDR, shiftDR, updateDR, scanin, D,
        output scanout, Q, update_pulse, len_err
    );
endinterface

// File: rtl/jtag_dr_shift_core.sv
// Shared capture/shift register with a saturating shifted-bit counter.
module jtag_dr_shift_core
    import jtag_sel_dr_bank_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = cnt_width(W)
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          cap_en,
    input  logic          shift_en,
    input  logic          cnt_en,
    input  logic [W-1:0]  cap_data,
    input  logic          scanin,
    output logic [W-1:0]  sr,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(W + 1);

    logic [W-1:0] sr_shifted;

    generate
        if (W == 1) begin : g_w1
            assign sr_shifted = scanin;
        end else begin : g_wn
            assign sr_shifted = {scanin, sr[W-1:1]};
        end
    endgenerate

    // Capture loads the register and restarts the count; shift moves LSB-first toward scanout.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            sr  <= '0;
            cnt <= '0;
        end else if (cap_en) begin
            sr  <= cap_data;
            cnt <= '0;
        end else if (shift_en) begin
            sr <= sr_shifted;
            if (cnt_en && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_sel_dr_bank.sv
// Bank of NUM_REGS JTAG update registers sharing one capture/shift register.
module jtag_sel_dr_bank
    import jtag_sel_dr_bank_pkg::*;
#(
    parameter int                      JTAG_REG_WIDTH = 16,
    parameter int                      NUM_REGS       = 4,
    parameter int                      SEL_W          = 2,
    parameter logic [JTAG_REG_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                clk,
    input  logic                reset_,
    jtag_sel_dr_bank_if.slave   bus
);

    localparam int W  = JTAG_REG_WIDTH;
    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);

    dr_state_e                     state_q, state_d;
    logic [SEL_W-1:0]              idx;
    logic [NUM_REGS-1:0][W-1:0]    q_r;
    logic [NUM_REGS-1:0]           pulse_r;
    logic [NUM_REGS-1:0]           pulse_d;
    logic                          len_err_r;
    logic [W-1:0]                  sr;
    logic [CW-1:0]                 cnt;
    logic [W-1:0]                  cap_data;
    logic                          cap, shf, upd, cnt_en, idx_ok, commit, reject;

    // Strobe priority: capture over shift over update, all gated by sel.
    assign cap    = bus.sel & bus.captureDR;
    assign shf    = bus.sel & bus.shiftDR & ~bus.captureDR;
    assign upd    = bus.sel & bus.updateDR & ~bus.captureDR & ~bus.shiftDR;
    assign cnt_en = shf & (state_q != IDLE);
    assign idx_ok = int'(idx) < NUM_REGS;
    assign commit = upd & (state_q != IDLE) & (cnt == CNT_FULL) & idx_ok;
    // Out-of-range indices are dropped quietly; everything else that fails to commit is a length error.
    assign reject = upd & ~commit & idx_ok;

    // Select the capture slice; unpopulated indices capture zeros.
    always_comb begin
        cap_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(bus.reg_sel) == k) cap_data = bus.D[slice_off(k, W) +: W];
        end
    end

    // One-hot strobe for the register being committed.
    always_comb begin
        pulse_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit && int'(idx) == k) pulse_d[k] = 1'b1;
        end
    end

    jtag_dr_shift_core #(.W(W), .CW(CW)) u_core (
        .clk      (clk),
        .reset_   (reset_),
        .cap_en   (cap),
        .shift_en (shf),
        .cnt_en   (cnt_en),
        .cap_data (cap_data),
        .scanin   (bus.scanin),
        .sr       (sr),
        .cnt      (cnt)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: capture arms, shift in an armed state advances, update always disarms.
    always_comb begin
        state_d = state_q;
        if (cap)                          state_d = CAPT;
        else if (shf && state_q != IDLE)  state_d = SHIFT;
        else if (upd)                     state_d = IDLE;
    end

    // Index latch, update registers, commit strobe and sticky length-error flag.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            idx       <= '0;
            q_r       <= {NUM_REGS{RESET_VALUE}};
            pulse_r   <= '0;
            len_err_r <= 1'b0;
        end else begin
            pulse_r <= pulse_d;
            if (cap) begin
                idx       <= bus.reg_sel;
                len_err_r <= 1'b0;
            end
            if (commit) q_r[idx] <= sr;
            if (reject) len_err_r <= 1'b1;
        end
    end

    assign bus.scanout      = bus.sel & sr[0];
    assign bus.Q            = q_r;
    assign bus.update_pulse = pulse_r;
    assign bus.len_err      = len_err_r;

endmodule

// File: tb/tb_jtag_sel_dr_bank.sv
// Randomized and directed bench for jtag_sel_dr_bank against a FIFO-style reference model.
module tb_jtag_sel_dr_bank;
    localparam int W  = 16;
    localparam int N  = 3;
    localparam int SW = 2;
    localparam logic [W-1:0] RV = 16'hA5A5;

    logic clk = 1'b0;
    logic reset_ = 1'b0;

    jtag_sel_dr_bank_if #(.JTAG_REG_WIDTH(W), .NUM_REGS(N), .SEL_W(SW)) bus ();

    jtag_sel_dr_bank #(
        .JTAG_REG_WIDTH(W), .NUM_REGS(N), .SEL_W(SW), .RESET_VALUE(RV)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the shift register seen as a bit queue (front = scanout),
    // plus "armed" flag, shifted-bit count, chosen index, and register contents.
    logic [W-1:0] m_q [N];
    bit           m_fifo [$];
    bit           m_act;
    int           m_n;
    int           m_idx;
    logic         m_err;
    logic [N-1:0] m_pulse;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_q[k] = RV;
        m_fifo.delete();
        for (int i = 0; i < W; i++) m_fifo.push_back(1'b0);
        m_act = 0; m_n = 0; m_idx = 0; m_err = 1'b0; m_pulse = '0;
    endtask

    task automatic model_step(input bit rst, input bit sl, input bit cp, input bit sh,
                              input bit up, input int rs, input bit si,
                              input logic [N*W-1:0] d);
        logic [W-1:0] v;
        m_pulse = '0;
        if (!rst) begin
            model_reset();
        end else if (sl) begin
            if (cp) begin
                m_idx = rs; m_n = 0; m_err = 1'b0; m_act = 1;
                m_fifo.delete();
                for (int i = 0; i < W; i++) m_fifo.push_back(rs < N ? d[rs*W + i] : 1'b0);
            end else if (sh) begin
                void'(m_fifo.pop_front());
                m_fifo.push_back(si);
                if (m_act && m_n < W + 1) m_n++;
            end else if (up) begin
                if (m_act && m_n == W && m_idx < N) begin
                    for (int i = 0; i < W; i++) v[i] = m_fifo[i];
                    m_q[m_idx] = v;
                    m_pulse[m_idx] = 1'b1;
                end else if (m_idx < N) begin
                    m_err = 1'b1;
                end
                m_act = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("scanout", 64'(bus.scanout), 64'(bus.sel ? m_fifo[0] : 1'b0));
        for (int k = 0; k < N; k++) chk($sformatf("q%0d", k), 64'(bus.Q[k*W +: W]), 64'(m_q[k]));
        chk("update_pulse", 64'(bus.update_pulse), 64'(m_pulse));
        chk("len_err", 64'(bus.len_err), 64'(m_err));
    endtask

    task automatic cyc(input bit rst, input bit sl, input bit cp, input bit sh,
                       input bit up, input int rs, input bit si);
        reset_        = rst;
        bus.sel       = sl;
        bus.captureDR = cp;
        bus.shiftDR   = sh;
        bus.updateDR  = up;
        bus.reg_sel   = rs[SW-1:0];
        bus.scanin    = si;
        @(posedge clk);
        model_step(rst, sl, cp, sh, up, rs, si, bus.D);
        #1;
        check_all();
    endtask

    // Capture from register rs, shift nbits of sdat (LSB first), then update and idle.
    task automatic xfer(input int rs, input logic [W-1:0] cdat, input logic [W-1:0] sdat,
                        input int nbits);
        if (rs < N) bus.D[rs*W +: W] = cdat;
        cyc(1, 1, 1, 0, 0, rs, 0);
        for (int i = 0; i < nbits; i++) cyc(1, 1, 0, 1, 0, rs, sdat[i % W]);
        cyc(1, 1, 0, 0, 1, rs, 0);
    endtask

    logic [W-1:0] seen;

    initial begin
        bus.sel = 0; bus.reg_sel = '0; bus.captureDR = 0; bus.shiftDR = 0;
        bus.updateDR = 0; bus.scanin = 0; bus.D = '0;
        model_reset();

        // Reset state.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reset_q0", 64'(bus.Q[0 +: W]), 64'(16'hA5A5));

        // Directed: capture 1234 from reg 2, shift in BEEF, observe scanout stream.
        bus.D = {16'h1234, 16'h5555, 16'h6666};
        cyc(1, 1, 1, 0, 0, 2, 0);
        seen = '0;
        for (int i = 0; i < W; i++) begin
            seen[i] = bus.scanout;
            cyc(1, 1, 0, 1, 0, 2, 16'hBEEF >> i);
        end
        chk("scan_1234", 64'(seen), 64'(16'h1234));
        cyc(1, 1, 0, 0, 1, 2, 0);
        chk("q2_beef", 64'(bus.Q[2*W +: W]), 64'(16'hBEEF));
        chk("pulse_0100", 64'(bus.update_pulse), 64'(3'b100));
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("pulse_once", 64'(bus.update_pulse), 64'(0));

        // Short and long shifts reject; next capture clears the flag.
        xfer(1, 16'h0F0F, 16'hCAFE, 15);
        chk("short_err", 64'(bus.len_err), 64'(1));
        xfer(1, 16'h0F0F, 16'hCAFE, 17);
        chk("long_err", 64'(bus.len_err), 64'(1));
        cyc(1, 1, 1, 0, 0, 0, 0);
        chk("cap_clears", 64'(bus.len_err), 64'(0));
        cyc(1, 1, 0, 0, 1, 0, 0);               // capture then update, no shift
        chk("noshift_err", 64'(bus.len_err), 64'(1));

        // Update without a prior capture.
        cyc(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) cyc(1, 1, 0, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0);
        chk("nocap_err", 64'(bus.len_err), 64'(1));

        // sel=0: strobes ignored, scanout forced low.
        for (int i = 0; i < 6; i++) cyc(1, 0, i[0], i[1], i[2], 2, 1);
        xfer(0, 16'h0001, 16'h00FF, 8);

        // Unpopulated index 3: zeros out, no commit, no error.
        cyc(1, 1, 1, 0, 0, 0, 0);                // clear len_err first
        xfer(3, 16'h0, 16'h1357, 16);
        chk("idx3_noerr", 64'(bus.len_err), 64'(0));

        // Capture and shift together: capture wins, count restarts.
        bus.D[0 +: W] = 16'h7E7E;
        cyc(1, 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < W; i++) cyc(1, 1, 0, 1, 0, 0, 16'h2468 >> i);
        cyc(1, 1, 1, 1, 1, 0, 0);
        cyc(1, 1, 0, 1, 1, 0, 1);
        xfer(0, 16'h7E7E, 16'h2468, 16);
        chk("q0_2468", 64'(bus.Q[0 +: W]), 64'(16'h2468));

        // Reset mid-shift, then a lone update.
        cyc(1, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 0, 1, 1);
        cyc(0, 1, 0, 1, 0, 1, 1);
        chk("midrst_q1", 64'(bus.Q[1*W +: W]), 64'(RV));
        for (int i = 0; i < 11; i++) cyc(1, 1, 0, 1, 0, 1, 1);
        cyc(1, 1, 0, 0, 1, 1, 0);
        chk("midrst_err", 64'(bus.len_err), 64'(1));

        // Randomized transactions with lengths around W.
        for (int t = 0; t < 60; t++) begin
            bus.D = {$urandom(), $urandom()};
            xfer($urandom_range(0, 3), W'($urandom()), W'($urandom()), $urandom_range(14, 18));
        end

        // Fully random strobe soup.
        for (int t = 0; t < 300; t++) begin
            bus.D = {$urandom(), $urandom()};
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 11) == 0), $urandom_range(0, 3), 1'($urandom()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
